ila_check_sequencer: RTL and testbench
======================================

ILA_CHECK_SEQUENCER -- requirements
Module: ila_check_sequencer

Interface
REQ-001 SHALL have parameters: W, 8, per-channel output width; NCH, 1, compared output channels; CNT_W, 5, cycle-counter width; MAX_CYCLE, 11, counter saturation value; END_CYCLE, 1, fixed end cycle; END_ON_READY, 0, 1 = end on rtl_ready instead of END_CYCLE; NINST, 1, back-to-back instructions per run.
REQ-002 SHALL use reset rst, synchronous, active-high; clock clk.
REQ-003 Ports: clk in 1 clock; rst in 1 sync reset; ila_valid in 1 spec-model valid; rtl_ready in 1 RTL completion strobe; ila_out in NCH*W spec outputs; rtl_out in NCH*W implementation outputs.
REQ-004 Ports: start out 1 start pulse; issue out 1 instruction issue; started out 1; cycle_cnt out CNT_W; inst_idx out clog2(NINST)+1; edcond out 1; iend out 1; ended out 1; ended2 out 1; reseted out 1; mismatch out 1; mismatch_vec out NCH; timeout out 1.

Function
REQ-005 SHALL implement FSM S_START -> S_RUN -> S_DONE, plus S_TIMEOUT; reset enters S_START.
REQ-006 S_START SHALL last exactly one cycle: start=1, issue=start&&ila_valid, cycle_cnt=0; then S_RUN with started=1.
REQ-007 cycle_cnt SHALL increment each cycle in S_RUN/S_DONE while below MAX_CYCLE, then hold at MAX_CYCLE (saturate, no wrap).
REQ-008 edcond SHALL equal started && (END_ON_READY ? rtl_ready : cycle_cnt==END_CYCLE), combinational.
REQ-009 iend SHALL equal edcond && reseted && !ended && state==S_RUN.
REQ-010 On iend with inst_idx<NINST-1: inst_idx+1, cycle_cnt=0, return to S_START (started stays 1).
REQ-011 On iend with inst_idx==NINST-1: ended=1 next cycle (sticky), enter S_DONE.
REQ-012 ended2 SHALL set (sticky) on first cycle with ended && edcond && !ended2.
REQ-013 On each iend, any channel with ila_out slice != rtl_out slice SHALL set mismatch (sticky) next cycle.
REQ-014 In S_RUN, cycle_cnt==MAX_CYCLE without iend SHALL set timeout (sticky), enter S_TIMEOUT; S_TIMEOUT exits only via rst.
REQ-015 iend and timeout same cycle: iend wins, timeout not set.
REQ-016 Outputs SHALL have zero combinational path from ila_out/rtl_out.

Reset
REQ-017 While rst: start=1 after release, started=0, cycle_cnt=0, inst_idx=0, ended=0, ended2=0, mismatch=0, mismatch_vec=0, timeout=0, reseted=1.
REQ-018 reseted SHALL never clear after set; rst mid-run SHALL abort and restart at S_START next cycle.

Configuration
REQ-019 Macro ILA_CHK_MISMATCH_VEC_EN defined: mismatch_vec[i] sticky per channel i per REQ-013, mismatch = OR of vector.
REQ-020 Macro undefined: mismatch_vec tied 0, only aggregate mismatch register implemented.

Structure
REQ-021 Shared package ila_chk_pkg SHALL hold FSM state enum and default parameter constants.
REQ-022 Sub-module ila_chk_cmp (per-channel compare/sticky flags) SHALL be instantiated once; rest is flat.

Verification
REQ-023 Defaults, ila_out=rtl_out=8'h5A: iend at cycle_cnt=1, ended=1 at cnt=2, mismatch=0, ended2=0.
REQ-024 NCH=2, W=8, at iend ila_out=16'h1234, rtl_out=16'h1235: mismatch=1; with macro, mismatch_vec=2'b01.
REQ-025 END_ON_READY=1, rtl_ready never: timeout=1 at cnt=11, FSM in S_TIMEOUT, ended=0.
REQ-026 NINST=3, END_CYCLE=2: three start pulses, inst_idx 0->1->2, ended=1 only after third iend.
REQ-027 END_ON_READY=1, rtl_ready at cnt=4 and 6: ended=1 at 5, ended2=1 at 7.
REQ-028 rst asserted at cnt=3 mid-run: all flags cleared, start=1 following cycle, reseted stays 1.

Source files
------------

// File: rtl/ila_chk_pkg.sv
// ila_chk_pkg: shared FSM state type and default parameter values for the ILA check sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ila_chk_pkg;

    // Sequencer phases: one start cycle, the run window, then one of two terminal states.
    typedef enum logic [1:0] {
        S_START   = 2'd0,
        S_RUN     = 2'd1,
        S_DONE    = 2'd2,
        S_TIMEOUT = 2'd3
    } ila_chk_state_t;

    // Default configuration of a single-channel, single-instruction check.
    localparam int ILA_CHK_W            = 8;
    localparam int ILA_CHK_NCH          = 1;
    localparam int ILA_CHK_CNT_W        = 5;
    localparam int ILA_CHK_MAX_CYCLE    = 11;
    localparam int ILA_CHK_END_CYCLE    = 1;
    localparam int ILA_CHK_END_ON_READY = 0;
    localparam int ILA_CHK_NINST        = 1;

endpackage

// File: rtl/ila_chk_cmp.sv
// ila_chk_cmp: per-channel compare of spec vs implementation outputs, latched into sticky flags.
// Latency: flags update one cycle after a capture strobe; outputs come only from flops.
// Backpressure: none, captures whenever capture is high.
// Config: ILA_CHK_MISMATCH_VEC_EN keeps one sticky flag per channel; otherwise a single flag.
module ila_chk_cmp
    import ila_chk_pkg::*;
#(
    parameter int W   = ILA_CHK_W,
    parameter int NCH = ILA_CHK_NCH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           capture,
    input  logic [NCH*W-1:0] ila_out,
    input  logic [NCH*W-1:0] rtl_out,
    output logic           mismatch,
    output logic [NCH-1:0] mismatch_vec
);

    logic [NCH-1:0] diff;

    // Per-channel inequality of the two output buses.
    always_comb begin
        diff = '0;
        for (int i = 0; i < NCH; i++) begin
            diff[i] = (ila_out[i*W +: W] != rtl_out[i*W +: W]);
        end
    end

`ifdef ILA_CHK_MISMATCH_VEC_EN
    logic [NCH-1:0] vec_q;

    // Accumulate differing channels at each capture point; cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q <= '0;
        end else if (capture) begin
            vec_q <= vec_q | diff;
        end
    end

    assign mismatch_vec = vec_q;
    assign mismatch     = |vec_q;
`else
    logic mm_q;

    // Single sticky flag: any channel differing at any capture point.
    always_ff @(posedge clk) begin
        if (rst) begin
            mm_q <= 1'b0;
        end else if (capture) begin
            mm_q <= mm_q | (|diff);
        end
    end

    assign mismatch_vec = '0;
    assign mismatch     = mm_q;
`endif

endmodule

// File: rtl/ila_check_sequencer.sv
// ila_check_sequencer: sequences start/run/end phases of an ILA-vs-RTL check and flags mismatches.
// Latency: start/issue in the first cycle after reset; end/mismatch/timeout flags one cycle after the event.
// Backpressure: none; the run ends on a fixed cycle count or on rtl_ready, and times out at MAX_CYCLE.
// Config: ILA_CHK_MISMATCH_VEC_EN enables per-channel sticky mismatch flags on mismatch_vec.
module ila_check_sequencer
    import ila_chk_pkg::*;
#(
    parameter int W            = ILA_CHK_W,
    parameter int NCH          = ILA_CHK_NCH,
    parameter int CNT_W        = ILA_CHK_CNT_W,
    parameter int MAX_CYCLE    = ILA_CHK_MAX_CYCLE,
    parameter int END_CYCLE    = ILA_CHK_END_CYCLE,
    parameter int END_ON_READY = ILA_CHK_END_ON_READY,
    parameter int NINST        = ILA_CHK_NINST
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ila_valid,
    input  logic                     rtl_ready,
    input  logic [NCH*W-1:0]         ila_out,
    input  logic [NCH*W-1:0]         rtl_out,
    output logic                     start,
    output logic                     issue,
    output logic                     started,
    output logic [CNT_W-1:0]         cycle_cnt,
    output logic [$clog2(NINST):0]   inst_idx,
    output logic                     edcond,
    output logic                     iend,
    output logic                     ended,
    output logic                     ended2,
    output logic                     reseted,
    output logic                     mismatch,
    output logic [NCH-1:0]           mismatch_vec,
    output logic                     timeout
);

    localparam int IDX_W = $clog2(NINST) + 1;

    ila_chk_state_t   state;
    logic             last_inst;
    logic             cnt_sat;
    logic [CNT_W-1:0] cnt_inc;

    assign last_inst = (inst_idx == IDX_W'(NINST - 1));
    assign cnt_sat   = (cycle_cnt == CNT_W'(MAX_CYCLE));
    assign cnt_inc   = cnt_sat ? cycle_cnt : cycle_cnt + 1'b1;

    // End-of-instruction detection: fixed cycle or RTL completion, only once the run has started.
    always_comb begin
        edcond = started && ((END_ON_READY != 0) ? rtl_ready
                                                 : (cycle_cnt == CNT_W'(END_CYCLE)));
        iend   = edcond && reseted && !ended && (state == S_RUN);
        issue  = start && ila_valid;
    end

    // Phase sequencer with registered status outputs; timeout only fires when no end coincides.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_START;
            start     <= 1'b1;
            started   <= 1'b0;
            cycle_cnt <= '0;
            inst_idx  <= '0;
            ended     <= 1'b0;
            ended2    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            // A second end condition after the final end marks the run as double-ended.
            if (ended && edcond && !ended2) begin
                ended2 <= 1'b1;
            end
            case (state)
                S_START: begin
                    state     <= S_RUN;
                    start     <= 1'b0;
                    started   <= 1'b1;
                    cycle_cnt <= '0;
                end
                S_RUN: begin
                    if (iend) begin
                        if (!last_inst) begin
                            // Back-to-back instruction: new start pulse, counter rewinds.
                            state     <= S_START;
                            start     <= 1'b1;
                            inst_idx  <= inst_idx + 1'b1;
                            cycle_cnt <= '0;
                        end else begin
                            state     <= S_DONE;
                            ended     <= 1'b1;
                            cycle_cnt <= cnt_inc;
                        end
                    end else if (cnt_sat) begin
                        state   <= S_TIMEOUT;
                        timeout <= 1'b1;
                    end else begin
                        cycle_cnt <= cnt_inc;
                    end
                end
                S_DONE: begin
                    cycle_cnt <= cnt_inc;
                end
                S_TIMEOUT: begin
                    // Terminal until reset; counter stays at its saturated value.
                    state <= S_TIMEOUT;
                end
            endcase
        end
    end

    // Records that a reset has been seen; never cleared afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            reseted <= 1'b1;
        end
    end

    ila_chk_cmp #(
        .W   (W),
        .NCH (NCH)
    ) u_cmp (
        .clk          (clk),
        .rst          (rst),
        .capture      (iend),
        .ila_out      (ila_out),
        .rtl_out      (rtl_out),
        .mismatch     (mismatch),
        .mismatch_vec (mismatch_vec)
    );

endmodule

// File: tb/tb_ila_check_sequencer.sv
// tb_ila_check_sequencer: four configurations driven in lockstep against a timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ila_check_sequencer;

    localparam int MAXC = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        ila_valid = 1'b0;
    logic        rtl_ready = 1'b0;
    logic [7:0]  ila8 = '0, rtl8 = '0;
    logic [15:0] ila16 = '0, rtl16 = '0;

    logic [3:0] start_o, issue_o, started_o, edcond_o, iend_o;
    logic [3:0] ended_o, ended2_o, reseted_o, mm_o, to_o;
    logic [4:0] cnt_o [4];
    logic       idx0, idx1, idx2;
    logic [2:0] idx3;
    logic       mv0, mv2, mv3;
    logic [1:0] mv1;

    int n_assert = 0;
    int n_fail   = 0;

    // d0: defaults
    ila_check_sequencer u_d0 (
        .clk(clk), .rst(rst), .ila_valid(ila_valid), .rtl_ready(rtl_ready),
        .ila_out(ila8), .rtl_out(rtl8), .start(start_o[0]), .issue(issue_o[0]),
        .started(started_o[0]), .cycle_cnt(cnt_o[0]), .inst_idx(idx0), .edcond(edcond_o[0]),
        .iend(iend_o[0]), .ended(ended_o[0]), .ended2(ended2_o[0]), .reseted(reseted_o[0]),
        .mismatch(mm_o[0]), .mismatch_vec(mv0), .timeout(to_o[0]));

    // d1: two channels
    ila_check_sequencer #(.NCH(2)) u_d1 (
        .clk(clk), .rst(rst), .ila_valid(ila_valid), .rtl_ready(rtl_ready),
        .ila_out(ila16), .rtl_out(rtl16), .start(start_o[1]), .issue(issue_o[1]),
        .started(started_o[1]), .cycle_cnt(cnt_o[1]), .inst_idx(idx1), .edcond(edcond_o[1]),
        .iend(iend_o[1]), .ended(ended_o[1]), .ended2(ended2_o[1]), .reseted(reseted_o[1]),
        .mismatch(mm_o[1]), .mismatch_vec(mv1), .timeout(to_o[1]));

    // d2: end on rtl_ready
    ila_check_sequencer #(.END_ON_READY(1)) u_d2 (
        .clk(clk), .rst(rst), .ila_valid(ila_valid), .rtl_ready(rtl_ready),
        .ila_out(ila8), .rtl_out(rtl8), .start(start_o[2]), .issue(issue_o[2]),
        .started(started_o[2]), .cycle_cnt(cnt_o[2]), .inst_idx(idx2), .edcond(edcond_o[2]),
        .iend(iend_o[2]), .ended(ended_o[2]), .ended2(ended2_o[2]), .reseted(reseted_o[2]),
        .mismatch(mm_o[2]), .mismatch_vec(mv2), .timeout(to_o[2]));

    // d3: three back-to-back instructions ending at cycle 2
    ila_check_sequencer #(.NINST(3), .END_CYCLE(2)) u_d3 (
        .clk(clk), .rst(rst), .ila_valid(ila_valid), .rtl_ready(rtl_ready),
        .ila_out(ila8), .rtl_out(rtl8), .start(start_o[3]), .issue(issue_o[3]),
        .started(started_o[3]), .cycle_cnt(cnt_o[3]), .inst_idx(idx3), .edcond(edcond_o[3]),
        .iend(iend_o[3]), .ended(ended_o[3]), .ended2(ended2_o[3]), .reseted(reseted_o[3]),
        .mismatch(mm_o[3]), .mismatch_vec(mv3), .timeout(to_o[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic string tg(input string nm, input string what, input int r);
        return $sformatf("%s.%s@r%0d", nm, what, r);
    endfunction

    // Timeline of a fixed-end run: each instruction is one start cycle plus cycles 0..e of run.
    function automatic void fixed_model(input int r, input int e, input int n,
                                        output int st, output int sd, output int cnt,
                                        output int idx, output int ie, output int en);
        int p, off;
        p   = e + 2;
        off = r % p;
        if (r < n * p) begin
            st  = int'(off == 0);
            cnt = (off == 0) ? 0 : off - 1;
            idx = r / p;
            ie  = int'(off == e + 1);
            en  = 0;
        end else begin
            st  = 0;
            cnt = e + 1 + r - n * p;
            if (cnt > MAXC) cnt = MAXC;
            idx = n - 1;
            ie  = 0;
            en  = 1;
        end
        sd = int'(r >= 1);
    endfunction

    task automatic chk_fixed(input int k, input int r, input int e, input int n,
                             input logic [31:0] idx_obs, input logic exp_mm, input string nm);
        int st, sd, cnt, idx, ie, en;
        fixed_model(r, e, n, st, sd, cnt, idx, ie, en);
        chk(tg(nm, "start", r),   32'(start_o[k]),   st);
        chk(tg(nm, "started", r), 32'(started_o[k]), sd);
        chk(tg(nm, "cnt", r),     32'(cnt_o[k]),     cnt);
        chk(tg(nm, "idx", r),     idx_obs,           idx);
        chk(tg(nm, "issue", r),   32'(issue_o[k]),   int'(st != 0 && ila_valid));
        chk(tg(nm, "edcond", r),  32'(edcond_o[k]),  int'(sd != 0 && cnt == e));
        chk(tg(nm, "iend", r),    32'(iend_o[k]),    ie);
        chk(tg(nm, "ended", r),   32'(ended_o[k]),   en);
        chk(tg(nm, "ended2", r),  32'(ended2_o[k]),  0);
        chk(tg(nm, "timeout", r), 32'(to_o[k]),      0);
        chk(tg(nm, "reseted", r), 32'(reseted_o[k]), 1);
        chk(tg(nm, "mismatch", r), 32'(mm_o[k]),     32'(exp_mm));
    endtask

    // Ready-ended run: counter runs r-1 (saturating) from the first run cycle regardless of phase.
    task automatic chk_ready(input int r, input int a, input int b, input logic exp_mm);
        int cnt;
        cnt = (r == 0) ? 0 : ((r - 1 > MAXC) ? MAXC : r - 1);
        chk(tg("d2", "start", r),   32'(start_o[2]),   int'(r == 0));
        chk(tg("d2", "started", r), 32'(started_o[2]), int'(r >= 1));
        chk(tg("d2", "cnt", r),     32'(cnt_o[2]),     cnt);
        chk(tg("d2", "idx", r),     32'(idx2),         0);
        chk(tg("d2", "edcond", r),  32'(edcond_o[2]),  int'(r >= 1 && rtl_ready));
        chk(tg("d2", "iend", r),    32'(iend_o[2]),    int'(a >= 0 && r == a + 1));
        chk(tg("d2", "ended", r),   32'(ended_o[2]),   int'(a >= 0 && r >= a + 2));
        chk(tg("d2", "ended2", r),  32'(ended2_o[2]),  int'(b >= 0 && r >= b + 2));
        chk(tg("d2", "timeout", r), 32'(to_o[2]),      int'(a < 0 && r >= MAXC + 2));
        chk(tg("d2", "mismatch", r), 32'(mm_o[2]),     32'(exp_mm));
    endtask

    // One reset-started run. rtl_ready pulses when d2's counter is at a and b (-1 = never).
    task automatic run_case(input int a, input int b, input int ncyc, input int force_r,
                            input logic [15:0] f_ila, input logic [15:0] f_rtl);
        logic       mm0, mm2, mm3;
        logic [1:0] mv1e;
        int st, sd, cnt, idx, ie, en;
        @(negedge clk);
        rst = 1'b1; ila_valid = 1'b0; rtl_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mm0 = 1'b0; mm2 = 1'b0; mm3 = 1'b0; mv1e = 2'b00;
        for (int r = 0; r < ncyc; r++) begin
            ila_valid = 1'($urandom_range(0, 1));
            rtl_ready = (a >= 0 && r == a + 1) || (b >= 0 && r == b + 1);
            ila16 = 16'($urandom);
            rtl16 = ila16;
            if ($urandom_range(0, 2) == 0) rtl16 = ila16 ^ (16'd1 << $urandom_range(0, 15));
            if (r == force_r) begin
                ila16 = f_ila;
                rtl16 = f_rtl;
            end
            ila8 = ila16[7:0];
            rtl8 = rtl16[7:0];
            #1;
            chk_fixed(0, r, 1, 1, 32'(idx0), mm0, "d0");
            chk_fixed(1, r, 1, 1, 32'(idx1), |mv1e, "d1");
            chk_fixed(3, r, 2, 3, 32'(idx3), mm3, "d3");
            chk_ready(r, a, b, mm2);
`ifdef ILA_CHK_MISMATCH_VEC_EN
            chk(tg("d1", "mvec", r), 32'(mv1), 32'(mv1e));
            chk(tg("d0", "mvec", r), 32'(mv0), 32'(mm0));
`else
            chk(tg("d1", "mvec", r), 32'(mv1), 0);
            chk(tg("d0", "mvec", r), 32'(mv0), 0);
`endif
            // A differing compare at an end-of-instruction cycle shows up from the next cycle.
            fixed_model(r, 1, 1, st, sd, cnt, idx, ie, en);
            if (ie != 0) begin
                mm0  = mm0 | (ila8 != rtl8);
                mv1e = mv1e | {ila16[15:8] != rtl16[15:8], ila16[7:0] != rtl16[7:0]};
            end
            fixed_model(r, 2, 3, st, sd, cnt, idx, ie, en);
            if (ie != 0) mm3 = mm3 | (ila8 != rtl8);
            if (a >= 0 && r == a + 1) mm2 = mm2 | (ila8 != rtl8);
            @(negedge clk);
        end
        rtl_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        // Defaults with equal data at the end cycle; d2 never sees rtl_ready and times out.
        run_case(-1, -1, 18, 2, 16'h5A5A, 16'h5A5A);
        // Ready at counts 4 and 6; two-channel difference in the low channel only.
        run_case(4, 6, 18, 2, 16'h1234, 16'h1235);
        // Ready exactly at the saturation count: end wins over timeout.
        run_case(11, -1, 16, -1, 16'h0, 16'h0);
        // Ready at the very first run cycle, second ready after the counter saturates.
        run_case(0, 11, 16, -1, 16'h0, 16'h0);

        // Reset in the middle of a run (d0 at count 3, mismatch latched).
        run_case(-1, -1, 4, 2, 16'h00AA, 16'h00AB);
        rst = 1'b1;
        #1;
        chk("d0.cnt_pre_rst",   32'(cnt_o[0]),   3);
        chk("d0.mm_pre_rst",    32'(mm_o[0]),    1);
        chk("d0.ended_pre_rst", 32'(ended_o[0]), 1);
        @(negedge clk);
        chk("d0.start_rst",   32'(start_o[0]),   1);
        chk("d0.started_rst", 32'(started_o[0]), 0);
        chk("d0.cnt_rst",     32'(cnt_o[0]),     0);
        chk("d0.idx_rst",     32'(idx0),         0);
        chk("d0.ended_rst",   32'(ended_o[0]),   0);
        chk("d0.ended2_rst",  32'(ended2_o[0]),  0);
        chk("d0.mm_rst",      32'(mm_o[0]),      0);
        chk("d0.mvec_rst",    32'(mv0),          0);
        chk("d0.to_rst",      32'(to_o[0]),      0);
        chk("d0.reseted_rst", 32'(reseted_o[0]), 1);
        chk("d2.to_rst",      32'(to_o[2]),      0);
        rst = 1'b0;
        @(negedge clk);
        chk("d0.start_after", 32'(start_o[0]),   0);
        chk("d0.started_after", 32'(started_o[0]), 1);
        chk("d0.reseted_after", 32'(reseted_o[0]), 1);

        // Randomized end points for the ready-ended configuration.
        for (int t = 0; t < 8; t++) begin
            int a, b;
            a = int'($urandom_range(0, 12)) - 1;
            b = -1;
            if (a >= 0 && a < MAXC && $urandom_range(0, 1) == 1) b = int'($urandom_range(a + 1, MAXC));
            run_case(a, b, 16, -1, 16'h0, 16'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
